// File: rtl/tone_sequencer.sv
// Keypad-to-PWM tone sequencer: debounce presses, queue up to four keys, play them as timed tones.
// Build option TONE_SEQ_REPLACE_EN: a press into a full queue overwrites the newest entry instead of being dropped.
module tone_sequencer #(
    parameter int DEB_CYCLES  = 500000,
    parameter int TONE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000,
    parameter int N_BASE      = 1000,
    parameter int N_STEP      = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        opr,
    input  logic [3:0]  posT,
    output logic [11:0] n_freq,
    output logic        pwm_en,
    output logic [3:0]  note_pos,
    output logic        busy,
    output logic [2:0]  q_count,
    output logic        overflow
);

    localparam logic [24:0] DEB_LAST  = 25'(DEB_CYCLES - 1);
    localparam logic [24:0] TONE_LAST = 25'(TONE_CYCLES - 1);
    localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);
    localparam logic [11:0] N_RESET   = 12'(N_BASE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    logic        r_s1, r_s2, r_deb_lvl, r_press_acc;
    logic [24:0] r_deb_cnt;
    logic [3:0]  r_press_pos;
    logic        w_deb_flip;

    logic [3:0]  r_mem [4];
    logic [1:0]  r_rd_ptr, r_wr_ptr;
    logic [2:0]  r_count;
    logic        r_overflow;
    logic        w_full, w_pop, w_push_ok, w_ovf;
    logic [3:0]  w_head;
    logic [31:0] w_n_calc;
    logic [11:0] w_n_sat;

    state_t      r_state, w_next_state;
    logic [24:0] r_tmr, w_next_tmr;

    // The flip fires on the DEB_CYCLES-th consecutive cycle that s2 disagrees with the debounced level.
    assign w_deb_flip = (r_s2 != r_deb_lvl) && (r_deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_deb_lvl   <= 1'b0;
            r_deb_cnt   <= '0;
            r_press_acc <= 1'b0;
            r_press_pos <= '0;
        end else begin
            r_s1 <= opr;
            r_s2 <= r_s1;
            if (r_s2 == r_deb_lvl) begin
                r_deb_cnt <= '0;
            end else if (w_deb_flip) begin
                r_deb_cnt <= '0;
                r_deb_lvl <= r_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + 25'd1;
            end
            r_press_acc <= w_deb_flip && r_s2;
            if (w_deb_flip && r_s2) begin
                r_press_pos <= posT;
            end
        end
    end

    assign w_full    = (r_count == 3'd4);
    assign w_head    = r_mem[r_rd_ptr];
    // A pop in the same cycle frees a slot, so a press into a full queue still lands.
    assign w_push_ok = r_press_acc && (!w_full || w_pop);
    assign w_ovf     = r_press_acc && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_press_pos;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
`ifdef TONE_SEQ_REPLACE_EN
            else if (w_ovf) begin
                r_mem[r_wr_ptr - 2'd1] <= r_press_pos;
            end
`endif
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            r_overflow <= w_ovf;
        end
    end

    assign w_n_calc = 32'(N_BASE) + 32'(N_STEP) * {28'd0, w_head};
    assign w_n_sat  = (w_n_calc > 32'd4095) ? 12'hFFF : w_n_calc[11:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_tmr   <= w_next_tmr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_tmr   = r_tmr;
        w_pop        = 1'b0;
        pwm_en       = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy       = 1'b0;
                w_next_tmr = '0;
                if (r_count != 3'd0) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop        = 1'b1;
                w_next_tmr   = '0;
                w_next_state = S_PLAY;
            end
            S_PLAY: begin
                pwm_en = 1'b1;
                if (r_tmr == TONE_LAST) begin
                    w_next_tmr   = '0;
                    w_next_state = S_GAP;
                end else begin
                    w_next_tmr = r_tmr + 25'd1;
                end
            end
            S_GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_next_tmr   = '0;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_tmr = r_tmr + 25'd1;
                end
            end
            default: begin
                w_next_tmr   = '0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Updated only on leaving LOAD, which is the edge PLAY starts, so N is stable for the whole tone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_freq   <= N_RESET;
            note_pos <= '0;
        end else if (r_state == S_LOAD) begin
            n_freq   <= w_n_sat;
            note_pos <= w_head;
        end
    end

    assign q_count  = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: three instances (short tone, long tone for queue filling, saturating N_BASE).
module tb_tone_sequencer;

    logic        clk;
    logic        rst;
    logic        opr;
    logic [3:0]  posT;

    logic [11:0] nf_d, nf_o, nf_s;
    logic        pwm_d, pwm_o, pwm_s;
    logic [3:0]  pos_d, pos_o, pos_s;
    logic        busy_d, busy_o, busy_s;
    logic [2:0]  q_d, q_o, q_s;
    logic        ovf_d, ovf_o, ovf_s;

    int checks = 0;
    int errors = 0;

    logic        prev_d, prev_o;
    logic [18:0] rec_d[$];
    logic [18:0] rec_o[$];
    int          ovf_o_cnt = 0;

    tone_sequencer #(.DEB_CYCLES(4), .TONE_CYCLES(20), .GAP_CYCLES(5), .N_BASE(1000), .N_STEP(100)) dut (
        .clk(clk), .rst(rst), .opr(opr), .posT(posT),
        .n_freq(nf_d), .pwm_en(pwm_d), .note_pos(pos_d), .busy(busy_d), .q_count(q_d), .overflow(ovf_d)
    );

    tone_sequencer #(.DEB_CYCLES(4), .TONE_CYCLES(100), .GAP_CYCLES(5), .N_BASE(1000), .N_STEP(100)) dut_ovf (
        .clk(clk), .rst(rst), .opr(opr), .posT(posT),
        .n_freq(nf_o), .pwm_en(pwm_o), .note_pos(pos_o), .busy(busy_o), .q_count(q_o), .overflow(ovf_o)
    );

    tone_sequencer #(.DEB_CYCLES(4), .TONE_CYCLES(20), .GAP_CYCLES(5), .N_BASE(4000), .N_STEP(100)) dut_sat (
        .clk(clk), .rst(rst), .opr(opr), .posT(posT),
        .n_freq(nf_s), .pwm_en(pwm_s), .note_pos(pos_s), .busy(busy_s), .q_count(q_s), .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot {q_count, note_pos, n_freq} at the first sample of every tone.
    always @(negedge clk) begin
        if (pwm_d && !prev_d) rec_d.push_back({q_d, pos_d, nf_d});
        if (pwm_o && !prev_o) rec_o.push_back({q_o, pos_o, nf_o});
        if (ovf_o) ovf_o_cnt <= ovf_o_cnt + 1;
        prev_d <= pwm_d;
        prev_o <= pwm_o;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        opr  = 1'b1;
        posT = k;
        step(6);
        opr  = 1'b0;
        step(6);
    endtask

    function automatic logic [18:0] mk(input logic [2:0] q, input logic [3:0] p, input logic [11:0] nf);
        return {q, p, nf};
    endfunction

    initial begin
        int t;
        int pwm_cnt;
        int bad;
        int base_d;
        int base_o;
        int ovf_base;
        logic [3:0] last_key;
        logic [18:0] exp_q[$];

        rst  = 1'b0;
        opr  = 1'b0;
        posT = 4'd0;
        step(2);

        // Reset held while opr toggles
        for (int i = 0; i < 6; i++) begin
            opr = ~opr;
            step(1);
        end
        opr = 1'b0;
        chk("rst_n_freq", nf_d, 1000);
        chk("rst_pwm_en", pwm_d, 0);
        chk("rst_note_pos", pos_d, 0);
        chk("rst_busy", busy_d, 0);
        chk("rst_q_count", q_d, 0);
        chk("rst_overflow", ovf_d, 0);
        chk("rst_sat_n_freq", nf_s, 4000);
        rst = 1'b1;
        step(5);
        chk("post_rst_n_freq", nf_d, 1000);
        chk("post_rst_busy", busy_d, 0);
        chk("post_rst_q_count", q_d, 0);
        chk("post_rst_pwm_en", pwm_d, 0);

        // Glitch of 3 cycles is shorter than DEB_CYCLES=4
        opr = 1'b1;
        step(3);
        opr = 1'b0;
        step(20);
        chk("glitch_q_count", q_d, 0);
        chk("glitch_pwm_en", pwm_d, 0);
        chk("glitch_busy", busy_d, 0);

        // Single note, key 5 held for 30 cycles; tone starts 9 edges after opr rises
        opr  = 1'b1;
        posT = 4'd5;
        step(7);
        chk("single_q_after_write", q_d, 1);
        chk("single_busy_idle", busy_d, 0);
        step(1);
        chk("single_busy_load", busy_d, 1);
        chk("single_pwm_load", pwm_d, 0);
        step(1);
        chk("single_pwm_start", pwm_d, 1);
        chk("single_n_freq", nf_d, 1500);
        chk("single_note_pos", pos_d, 5);
        chk("single_q_after_pop", q_d, 0);
        pwm_cnt = 1;
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            if (pwm_d) pwm_cnt++;
            if (nf_d !== 12'd1500 || pos_d !== 4'd5) bad++;
        end
        step(1);
        chk("single_pwm_end", pwm_d, 0);
        chk("single_pwm_len", pwm_cnt, 20);
        chk("single_n_freq_stable", bad, 0);
        chk("single_busy_gap", busy_d, 1);
        step(1);
        opr = 1'b0;
        step(3);
        chk("single_busy_gap_last", busy_d, 1);
        step(1);
        chk("single_busy_done", busy_d, 0);
        chk("single_n_freq_hold", nf_d, 1500);
        chk("single_note_pos_hold", pos_d, 5);
        step(20);

        // Queue order: keys 1,2,3
        base_d = rec_d.size();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        t = 0;
        while (rec_d.size() < base_d + 3 && t < 400) begin
            step(1);
            t++;
        end
        chk("queue_notes_seen", (rec_d.size() >= base_d + 3), 1);
        exp_q.delete();
        exp_q.push_back(mk(3'd0, 4'd1, 12'd1100));
        exp_q.push_back(mk(3'd1, 4'd2, 12'd1200));
        exp_q.push_back(mk(3'd0, 4'd3, 12'd1300));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("queue_note%0d", i), rec_d[base_d + i], exp_q.pop_front());
        end

        // Overflow on the long-tone instance: key 0 plays, 1..4 fill the queue, 5 meets a full queue
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        base_o   = rec_o.size();
        ovf_base = ovf_o_cnt;
        for (int k = 0; k < 6; k++) begin
            press(4'(k));
        end
        chk("ovf_q_full", q_o, 4);
        chk("ovf_pulse_count", ovf_o_cnt - ovf_base, 1);
        chk("ovf_first_playing", pwm_o, 1);
        chk("ovf_first_pos", pos_o, 0);
`ifdef TONE_SEQ_REPLACE_EN
        last_key = 4'd5;
`else
        last_key = 4'd4;
`endif
        t = 0;
        while (rec_o.size() < base_o + 5 && t < 800) begin
            step(1);
            t++;
        end
        chk("ovf_notes_seen", (rec_o.size() >= base_o + 5), 1);
        exp_q.delete();
        exp_q.push_back(mk(3'd0, 4'd0, 12'd1000));
        exp_q.push_back(mk(3'd3, 4'd1, 12'd1100));
        exp_q.push_back(mk(3'd2, 4'd2, 12'd1200));
        exp_q.push_back(mk(3'd1, 4'd3, 12'd1300));
        exp_q.push_back(mk(3'd0, last_key, 12'(1000 + 100 * int'(last_key))));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_note%0d", i), rec_o[base_o + i], exp_q.pop_front());
        end

        // Saturation: key 15 on N_BASE=4000
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        press(4'd15);
        chk("sat_pwm_en", pwm_s, 1);
        chk("sat_n_freq", nf_s, 4095);
        chk("sat_note_pos", pos_s, 15);
        chk("key15_n_freq", nf_d, 2500);

        // Reset in the middle of a tone with one note queued
        press(4'd7);
        chk("midrst_pwm_before", pwm_d, 1);
        chk("midrst_q_before", q_d, 1);
        rst = 1'b0;
        #1;
        chk("midrst_pwm_en", pwm_d, 0);
        chk("midrst_busy", busy_d, 0);
        chk("midrst_q_count", q_d, 0);
        chk("midrst_n_freq", nf_d, 1000);
        step(2);
        rst = 1'b1;
        step(10);
        chk("midrst_stays_idle", busy_d, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Sits between the keypad scanner and the PWM tone generator.
- Debounces the keypad "pressed" flag and captures the key position on each accepted press, queueing it in a 4-entry FIFO.
- Plays queued notes one at a time: drives the PWM period value N and an enable for a fixed tone length, then a silent gap.
- Exposes the playing note and queue status for the 7-segment display.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a level change on opr (10 ms at 50 MHz); legal range 1..2^25-1.
- TONE_CYCLES, 25000000: cycles pwm_en stays high per note; legal range 1..2^25-1.
- GAP_CYCLES, 2500000: silent cycles after each note; legal range 1..2^25-1.
- N_BASE, 1000: N for key 0.
- N_STEP, 100: N increment per key position.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- opr  in  1  keypad pressed flag, asynchronous level.
- posT  in  4  keypad position 0..15; valid while opr is high.
- n_freq  out  12  N value to the PWM generator.
- pwm_en  out  1  tone enable to the PWM generator.
- note_pos  out  4  position of the note currently or last played.
- busy  out  1  high in any state other than IDLE.
- q_count  out  3  FIFO occupancy, 0..4.
- overflow  out  1  one-cycle pulse when a press meets a full FIFO.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - n_freq=N_BASE[11:0], pwm_en=0, note_pos=0, busy=0, q_count=0, overflow=0.
  - FIFO pointers to 0, state=IDLE, all counters to 0, debounced level to 0, sync flops to 0.
- Synchronizer: opr passes through 2 flops (s1, s2); posT is sampled from the raw input on the accept cycle.
- Debounce:
  - A counter increments while s2 differs from the debounced level and clears when they match.
  - When the count reaches DEB_CYCLES the debounced level flips and the counter clears.
  - A glitch shorter than DEB_CYCLES is ignored.
- Press accept: a one-cycle press_acc pulse on the debounced 0->1 transition. Releases generate nothing. Holding a key yields exactly one press.
- FIFO (4 x 4 bits): on press_acc, posT is written in the same cycle.
  - If full and no pop in that cycle: write dropped, overflow=1 for one cycle.
  - If full and pop in the same cycle: pop takes effect first and the write succeeds, no overflow.
- n_freq arithmetic: computed at 13 bits as N_BASE + N_STEP*pos; a result >4095 saturates to 4095.
- FSM states:
  - IDLE: pwm_en=0, busy=0. If q_count!=0, go to LOAD.
  - LOAD (1 cycle): pop FIFO head; register note_pos=head and n_freq=f(head); go to PLAY.
  - PLAY: pwm_en=1 for exactly TONE_CYCLES cycles, then go to GAP.
  - GAP: pwm_en=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- n_freq and note_pos hold their last value outside LOAD.
- n_freq is never changed while pwm_en=1, so the PWM generator sees a stable N for the whole tone.
- Latency: press_acc at edge k -> FIFO write at k -> IDLE sees q_count=1 at k+1 -> LOAD at k+2 -> pwm_en=1 from edge k+3.
- Back-to-back notes: after GAP, IDLE lasts exactly 1 cycle before the next LOAD.
- Presses during PLAY or GAP are queued and do not disturb the current note.
- Reset mid-note: pwm_en drops immediately (asynchronous) and the queue is emptied.

Optional Feature:
- TONE_SEQ_REPLACE_EN defined: a press into a full FIFO overwrites the newest entry (tail-1) instead of being dropped. overflow still pulses, q_count stays 4.
- TONE_SEQ_REPLACE_EN undefined: the press is dropped as described above.

Test Plan:
- Reset check: rst=0 with opr toggling -> all outputs at reset values; release rst -> still idle, n_freq=1000.
- Single note (DEB=4, TONE=20, GAP=5): hold opr=1 with posT=5 for 30 cycles -> pwm_en=1 for exactly 20 cycles starting press_acc+3; n_freq=1500 and note_pos=5 throughout; busy falls 5 cycles after pwm_en falls.
- Glitch: opr=1 for 3 cycles with DEB=4 -> no press_acc, q_count=0, pwm_en=0.
- Queue order: press keys 1,2,3 quickly -> notes play as n_freq=1100, 1200, 1300 in order; q_count decrements at each LOAD.
- Overflow: 6 presses during the first tone (keys 0..5) -> 0 plays, 1..4 queued, press of 5 pulses overflow and is dropped. With TONE_SEQ_REPLACE_EN: the last note played is 5, not 4.
- Saturation: N_BASE=4000, N_STEP=100, key 15 -> n_freq=4095.
